aes_cmd_sequencer: RTL and testbench
====================================

AES_CMD_SEQUENCER -- requirements
Module: aes_cmd_sequencer

Parameters
REQ-001 The block SHALL have parameter DIN_W, default 8, meaning cipher data-bus width in bits; legal values are 8, 16 and 32.
REQ-002 The block SHALL have parameter KEY_BITS, default 128, meaning key length; legal values are 128, 192 and 256.
REQ-003 The block SHALL have parameter NUM_BLOCKS, default 20, meaning the number of ok pulses after which the run completes.
REQ-004 The block SHALL have parameter GAP_CYC, default 2, meaning the number of idle cycles between command phases.
REQ-005 The block SHALL have parameter TMO_CYC, default 1024, meaning the maximum number of cycles to wait for ok.

Interface
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: single-cycle run request, accepted only in IDLE.
REQ-009 The block SHALL have port key_in, input, KEY_BITS bits: key, sampled on start acceptance.
REQ-010 The block SHALL have ports pt_in, input, 128 bits, and pt_valid, input, 1 bit: plaintext with its valid flag.
REQ-011 The block SHALL have port pt_ready, output, 1 bit: plaintext accepted when pt_valid and pt_ready are both high.
REQ-012 The block SHALL have port cmd, output, 2 bits: ID=00, ST=01, SK=10, SP=11.
REQ-013 The block SHALL have port din, output, DIN_W bits: cipher data beat.
REQ-014 The block SHALL have ports ok, input, 1 bit, and ready, input, 1 bit: the cipher status signals.
REQ-015 The block SHALL have ports busy, done and tmo_err, outputs, 1 bit each: status flags.
REQ-016 The block SHALL have port blk_cnt, output, 16 bits: the number of completed blocks.

Function
REQ-017 The block SHALL implement the states IDLE, KEY, GAPK, WAITPT, PT, GAPP, ST, WAITOK, DONE and ERR.
REQ-018 In IDLE, when start=1 the block SHALL capture key_in, clear blk_cnt and go to KEY; start in any other state SHALL be ignored.
REQ-019 In KEY the block SHALL drive cmd=SK for one preamble cycle with din=0, then for KEY_BITS/DIN_W beats with din taken from the captured key, least significant chunk first.
REQ-020 In GAPK and in GAPP the block SHALL drive cmd=ID and din=0 for exactly GAP_CYC cycles.
REQ-021 In WAITPT the block SHALL drive pt_ready=1 and cmd=ID; on a handshake it SHALL capture pt_in and go to PT in the next cycle.
REQ-022 pt_ready SHALL be high only in WAITPT.
REQ-023 In PT the block SHALL drive cmd=SP for one preamble cycle with din=0, then for 128/DIN_W beats with din taken from the captured plaintext, LSB chunk first.
REQ-024 In ST the block SHALL drive cmd=ST for 2 cycles, but only if ready=1 on entry; otherwise it SHALL hold cmd=ID until ready=1.
REQ-025 In WAITOK the block SHALL drive cmd=ID and count cycles.
REQ-026 In WAITOK, on ok=1 the block SHALL increment blk_cnt in the same cycle; it SHALL then go to DONE if the new blk_cnt equals NUM_BLOCKS, otherwise to WAITPT.
REQ-027 In WAITOK, if TMO_CYC cycles elapse without ok, the block SHALL go to ERR and set tmo_err=1.
REQ-028 The key SHALL be loaded only once per run.
REQ-029 An ok pulse that arrives outside WAITOK SHALL be ignored and SHALL NOT increment blk_cnt.
REQ-030 If ok arrives in the same cycle as the timeout expires, ok SHALL take priority.
REQ-031 busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-032 In DONE, done SHALL be 1 and held; both DONE and ERR SHALL return to IDLE on start, clearing done, tmo_err and blk_cnt.
REQ-033 blk_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-034 When rst=1 at a clock edge, the block SHALL go to IDLE with cmd=ID, din=0, pt_ready=0, busy=0, done=0, tmo_err=0 and blk_cnt=0, and SHALL clear all internal counters.
REQ-035 Reset SHALL take priority over start and ok, and SHALL abort any phase mid-beat with no further SK or SP beats emitted.

Verification
REQ-036 The bench SHALL cover: defaults, key 2475a2b33475568831e2120013aa5487 -> SK preamble then 16 beats 87,54,aa,13,...,24, then 2 ID cycles, then pt_ready=1.
REQ-037 The bench SHALL cover: DIN_W=32, plaintext 00041214120412000c00131108231919 -> SP preamble then 4 beats 08231919,0c001311,12041200,00041214, then 2 ID cycles, then ST for 2 cycles.
REQ-038 The bench SHALL cover: a cipher model returning ok 10 cycles after ST, NUM_BLOCKS=20, pt_valid held high -> blk_cnt reaches 20, done=1, and SK appears only once.
REQ-039 The bench SHALL cover: ok never asserted, TMO_CYC=16 -> tmo_err=1 exactly 16 cycles after WAITOK entry, busy=0.
REQ-040 The bench SHALL cover: rst=1 during the 5th PT beat -> the next cycle shows cmd=ID, blk_cnt=0, busy=0, and no further SP beats.
REQ-041 The bench SHALL cover: ok pulsed during KEY, and ok coincident with the timeout -> the first leaves blk_cnt unchanged; the second gives blk_cnt+1 and tmo_err=0.

Source files
------------

// File: rtl/aes_cmd_sequencer.sv
// AES command sequencer: loads the key once per run, then streams plaintext
// blocks to a serial cipher core, issuing start and counting ok completions.
module aes_cmd_sequencer #(
   parameter int unsigned DIN_W      = 8,
   parameter int unsigned KEY_BITS   = 128,
   parameter int unsigned NUM_BLOCKS = 20,
   parameter int unsigned GAP_CYC    = 2,
   parameter int unsigned TMO_CYC    = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   input  logic [127:0]        pt_in,
   input  logic                pt_valid,
   output logic                pt_ready,
   output logic [1:0]          cmd,
   output logic [DIN_W-1:0]    din,
   input  logic                ok,
   input  logic                ready,
   output logic                busy,
   output logic                done,
   output logic                tmo_err,
   output logic [15:0]         blk_cnt
);

   localparam int unsigned KEY_BEATS = KEY_BITS / DIN_W;
   localparam int unsigned PT_BEATS  = 128 / DIN_W;
   localparam int unsigned MAX_A     = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
   localparam int unsigned MAX_C     = (MAX_A > KEY_BEATS) ? MAX_A : KEY_BEATS;
   localparam int unsigned CNT_W     = $clog2(MAX_C + 1);

   localparam logic [1:0] CMD_ID = 2'b00;
   localparam logic [1:0] CMD_ST = 2'b01;
   localparam logic [1:0] CMD_SK = 2'b10;
   localparam logic [1:0] CMD_SP = 2'b11;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_KEY    = 4'd1;
   localparam logic [3:0] S_GAPK   = 4'd2;
   localparam logic [3:0] S_WAITPT = 4'd3;
   localparam logic [3:0] S_PT     = 4'd4;
   localparam logic [3:0] S_GAPP   = 4'd5;
   localparam logic [3:0] S_ST     = 4'd6;
   localparam logic [3:0] S_WAITOK = 4'd7;
   localparam logic [3:0] S_DONE   = 4'd8;
   localparam logic [3:0] S_ERR    = 4'd9;

   logic [3:0]          state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [15:0]         blk_n, blk_inc;
   logic [KEY_BITS-1:0] key_q;
   logic [127:0]        pt_q;
   logic                key_ld, pt_ld;

   logic [1:0]       cmd_n;
   logic [DIN_W-1:0] din_n;
   logic             pt_ready_n, busy_n, done_n, tmo_n;

   // Next state and counters. In ST, cnt=0 means holding ID until ready,
   // cnt=1..2 are the two ST cycles.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      blk_n   = blk_cnt;
      key_ld  = 1'b0;
      pt_ld   = 1'b0;
      blk_inc = (blk_cnt == 16'hFFFF) ? blk_cnt : blk_cnt + 16'd1;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_KEY;
               cnt_n   = '0;
               blk_n   = '0;
               key_ld  = 1'b1;
            end
         end
         S_KEY: begin
            if (cnt == CNT_W'(KEY_BEATS)) begin
               state_n = S_GAPK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_GAPK: begin
            if (cnt == CNT_W'(GAP_CYC - 1)) begin
               state_n = S_WAITPT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_WAITPT: begin
            if (pt_valid) begin
               state_n = S_PT;
               cnt_n   = '0;
               pt_ld   = 1'b1;
            end
         end
         S_PT: begin
            if (cnt == CNT_W'(PT_BEATS)) begin
               state_n = S_GAPP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_GAPP: begin
            if (cnt == CNT_W'(GAP_CYC - 1)) begin
               state_n = S_ST;
               cnt_n   = ready ? CNT_W'(1) : '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_ST: begin
            if (cnt == CNT_W'(2)) begin
               state_n = S_WAITOK;
               cnt_n   = '0;
            end else if ((cnt != '0) || ready) begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_WAITOK: begin
            // ok wins over a timeout expiring in the same cycle
            if (ok) begin
               blk_n   = blk_inc;
               state_n = (blk_inc == 16'(NUM_BLOCKS)) ? S_DONE : S_WAITPT;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(TMO_CYC - 1)) begin
               state_n = S_ERR;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_DONE, S_ERR: begin
            if (start) begin
               state_n = S_IDLE;
               cnt_n   = '0;
               blk_n   = '0;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Output decode of the upcoming state so every output leaves a flop.
   always_comb begin
      cmd_n      = CMD_ID;
      din_n      = '0;
      pt_ready_n = 1'b0;
      busy_n     = 1'b1;
      done_n     = 1'b0;
      tmo_n      = 1'b0;
      case (state_n)
         S_IDLE: busy_n = 1'b0;
         S_KEY: begin
            cmd_n = CMD_SK;
            if (cnt_n != '0) din_n = DIN_W'(key_q >> (DIN_W * (32'(cnt_n) - 32'd1)));
         end
         S_WAITPT: pt_ready_n = 1'b1;
         S_PT: begin
            cmd_n = CMD_SP;
            if (cnt_n != '0) din_n = DIN_W'(pt_q >> (DIN_W * (32'(cnt_n) - 32'd1)));
         end
         S_ST: cmd_n = (cnt_n != '0) ? CMD_ST : CMD_ID;
         S_DONE: begin
            busy_n = 1'b0;
            done_n = 1'b1;
         end
         S_ERR: begin
            busy_n = 1'b0;
            tmo_n  = 1'b1;
         end
         default: busy_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         blk_cnt  <= '0;
         key_q    <= '0;
         pt_q     <= '0;
         cmd      <= CMD_ID;
         din      <= '0;
         pt_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tmo_err  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         blk_cnt  <= blk_n;
         if (key_ld) key_q <= key_in;
         if (pt_ld)  pt_q  <= pt_in;
         cmd      <= cmd_n;
         din      <= din_n;
         pt_ready <= pt_ready_n;
         busy     <= busy_n;
         done     <= done_n;
         tmo_err  <= tmo_n;
      end
   end

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: an 8-bit default instance and a
// 32-bit instance with a short timeout, driven by per-scenario tasks.
module tb_aes_cmd_sequencer;

   localparam logic [1:0] ID = 2'b00;
   localparam logic [1:0] ST = 2'b01;
   localparam logic [1:0] SK = 2'b10;
   localparam logic [1:0] SP = 2'b11;

   localparam logic [7:0] KEXP [16] = '{8'h87, 8'h54, 8'haa, 8'h13, 8'h00, 8'h12, 8'he2, 8'h31,
                                        8'h88, 8'h56, 8'h75, 8'h34, 8'hb3, 8'ha2, 8'h75, 8'h24};
   localparam logic [7:0]  PEXP8  [5] = '{8'hff, 8'hee, 8'hdd, 8'hcc, 8'hbb};
   localparam logic [31:0] KEXP32 [4] = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c};
   localparam logic [31:0] PEXP32 [4] = '{32'h08231919, 32'h0c001311, 32'h12041200, 32'h00041214};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic         rst_a, start_a, pt_valid_a, ok_a, ready_a;
   logic [127:0] key_a, pt_a;
   logic         pt_ready_a, busy_a, done_a, tmo_a;
   logic [1:0]   cmd_a;
   logic [7:0]   din_a;
   logic [15:0]  blk_a;

   logic         rst_b, start_b, pt_valid_b, ok_b, ready_b;
   logic [127:0] key_b, pt_b;
   logic         pt_ready_b, busy_b, done_b, tmo_b;
   logic [1:0]   cmd_b;
   logic [31:0]  din_b;
   logic [15:0]  blk_b;

   aes_cmd_sequencer u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .key_in(key_a), .pt_in(pt_a),
      .pt_valid(pt_valid_a), .pt_ready(pt_ready_a), .cmd(cmd_a), .din(din_a),
      .ok(ok_a), .ready(ready_a), .busy(busy_a), .done(done_a), .tmo_err(tmo_a),
      .blk_cnt(blk_a)
   );

   aes_cmd_sequencer #(.DIN_W(32), .TMO_CYC(16)) u_b (
      .clk(clk), .rst(rst_b), .start(start_b), .key_in(key_b), .pt_in(pt_b),
      .pt_valid(pt_valid_b), .pt_ready(pt_ready_b), .cmd(cmd_b), .din(din_b),
      .ok(ok_b), .ready(ready_b), .busy(busy_b), .done(done_b), .tmo_err(tmo_b),
      .blk_cnt(blk_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; start_a = 1'b0; pt_valid_a = 1'b0; ok_a = 1'b0; ready_a = 1'b1;
      rst_b = 1'b1; start_b = 1'b0; pt_valid_b = 1'b0; ok_b = 1'b0; ready_b = 1'b1;
      key_a = '0; pt_a = '0; key_b = '0; pt_b = '0;
      tick(); tick();
      rst_a = 1'b0; rst_b = 1'b0;
      checks++;
      if (cmd_a !== ID || din_a !== 8'h0 || pt_ready_a !== 1'b0 || busy_a !== 1'b0 ||
          done_a !== 1'b0 || tmo_a !== 1'b0 || blk_a !== 16'd0) begin
         errors++;
         $display("FAIL reset_a: cmd=%0d din=%h prdy=%b busy=%b done=%b tmo=%b blk=%0d, want all 0",
                  cmd_a, din_a, pt_ready_a, busy_a, done_a, tmo_a, blk_a);
      end
      checks++;
      if (cmd_b !== ID || din_b !== 32'h0 || pt_ready_b !== 1'b0 || busy_b !== 1'b0 ||
          done_b !== 1'b0 || tmo_b !== 1'b0 || blk_b !== 16'd0) begin
         errors++;
         $display("FAIL reset_b: cmd=%0d din=%h prdy=%b busy=%b done=%b tmo=%b blk=%0d, want all 0",
                  cmd_b, din_b, pt_ready_b, busy_b, done_b, tmo_b, blk_b);
      end
   endtask

   // Key load on the 8-bit instance, with ok and a second start thrown in mid-key.
   task automatic test_key_load();
      int bad;
      key_a = 128'h2475a2b33475568831e2120013aa5487;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checks++;
      if (cmd_a !== SK || din_a !== 8'h00 || busy_a !== 1'b1) begin
         errors++;
         $display("FAIL key_preamble: cmd=%0d din=%h busy=%b, want cmd=2 din=00 busy=1", cmd_a, din_a, busy_a);
      end
      for (int i = 0; i < 16; i++) begin
         ok_a    = (i == 3);
         start_a = (i == 6);
         tick();
         checks++;
         if (cmd_a !== SK || din_a !== KEXP[i]) begin
            errors++;
            $display("FAIL key_beat%0d: cmd=%0d din=%h, want cmd=2 din=%h", i, cmd_a, din_a, KEXP[i]);
         end
      end
      ok_a = 1'b0; start_a = 1'b0;
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (cmd_a !== ID || din_a !== 8'h00 || pt_ready_a !== 1'b0 || busy_a !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL key_gap: %0d bad gap cycles, want 0", bad);
      end
      tick();
      checks++;
      if (pt_ready_a !== 1'b1 || cmd_a !== ID || blk_a !== 16'd0) begin
         errors++;
         $display("FAIL key_waitpt: prdy=%b cmd=%0d blk=%0d, want prdy=1 cmd=0 blk=0", pt_ready_a, cmd_a, blk_a);
      end
   endtask

   // Reset on the 5th SP beat of the 8-bit instance.
   task automatic test_reset_mid_pt();
      int sp_seen;
      pt_a = 128'h00112233445566778899aabbccddeeff;
      pt_valid_a = 1'b1;
      tick();
      pt_valid_a = 1'b0;
      checks++;
      if (cmd_a !== SP || din_a !== 8'h00 || pt_ready_a !== 1'b0) begin
         errors++;
         $display("FAIL pt8_preamble: cmd=%0d din=%h prdy=%b, want cmd=3 din=00 prdy=0", cmd_a, din_a, pt_ready_a);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (cmd_a !== SP || din_a !== PEXP8[i]) begin
            errors++;
            $display("FAIL pt8_beat%0d: cmd=%0d din=%h, want cmd=3 din=%h", i, cmd_a, din_a, PEXP8[i]);
         end
      end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      checks++;
      if (cmd_a !== ID || din_a !== 8'h00 || blk_a !== 16'd0 || busy_a !== 1'b0 || pt_ready_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_pt: cmd=%0d din=%h blk=%0d busy=%b prdy=%b, want all 0",
                  cmd_a, din_a, blk_a, busy_a, pt_ready_a);
      end
      sp_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cmd_a == SP) sp_seen++;
      end
      checks++;
      if (sp_seen != 0 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_more_sp: sp_cycles=%0d busy=%b, want 0 and 0", sp_seen, busy_a);
      end
   endtask

   // 32-bit instance: key beats, plaintext beats, gap and ST.
   task automatic test_pt_load();
      int bad;
      key_b = 128'h0f0e0d0c0b0a09080706050403020100;
      ready_b = 1'b1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (cmd_b !== SK || din_b !== KEXP32[i]) begin
            errors++;
            $display("FAIL key32_beat%0d: cmd=%0d din=%h, want cmd=2 din=%h", i, cmd_b, din_b, KEXP32[i]);
         end
      end
      tick(); tick(); tick();
      checks++;
      if (pt_ready_b !== 1'b1 || cmd_b !== ID) begin
         errors++;
         $display("FAIL pt32_waitpt: prdy=%b cmd=%0d, want prdy=1 cmd=0", pt_ready_b, cmd_b);
      end
      pt_b = 128'h00041214120412000c00131108231919;
      pt_valid_b = 1'b1;
      tick();
      pt_valid_b = 1'b0;
      checks++;
      if (cmd_b !== SP || din_b !== 32'h0 || pt_ready_b !== 1'b0) begin
         errors++;
         $display("FAIL pt32_preamble: cmd=%0d din=%h prdy=%b, want cmd=3 din=0 prdy=0", cmd_b, din_b, pt_ready_b);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (cmd_b !== SP || din_b !== PEXP32[i]) begin
            errors++;
            $display("FAIL pt32_beat%0d: cmd=%0d din=%h, want cmd=3 din=%h", i, cmd_b, din_b, PEXP32[i]);
         end
      end
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (cmd_b !== ID || din_b !== 32'h0) bad++;
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         if (cmd_b !== ST) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL pt32_gap_st: %0d bad cycles in gap+ST, want 0", bad);
      end
      tick();
      checks++;
      if (cmd_b !== ID || busy_b !== 1'b1 || tmo_b !== 1'b0) begin
         errors++;
         $display("FAIL waitok_entry: cmd=%0d busy=%b tmo=%b, want 0 1 0", cmd_b, busy_b, tmo_b);
      end
   endtask

   // Continues from WAITOK entry: no ok, so the error lands 16 cycles later.
   task automatic test_timeout();
      int bad;
      bad = 0;
      for (int k = 1; k < 16; k++) begin
         tick();
         if (tmo_b !== 1'b0 || busy_b !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL tmo_early: %0d cycles with tmo set or busy low before 16, want 0", bad);
      end
      tick();
      checks++;
      if (tmo_b !== 1'b1 || busy_b !== 1'b0 || cmd_b !== ID) begin
         errors++;
         $display("FAIL tmo_at16: tmo=%b busy=%b cmd=%0d, want 1 0 0", tmo_b, busy_b, cmd_b);
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      checks++;
      if (tmo_b !== 1'b0 || busy_b !== 1'b0 || blk_b !== 16'd0 || done_b !== 1'b0) begin
         errors++;
         $display("FAIL err_restart: tmo=%b busy=%b blk=%0d done=%b, want all 0", tmo_b, busy_b, blk_b, done_b);
      end
   endtask

   // ready held low at ST entry, then ok coincident with the timeout.
   task automatic test_coincident_ok();
      int n, bad;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      n = 0;
      while (pt_ready_b !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (pt_ready_b !== 1'b1) begin
         errors++;
         $display("FAIL coinc_waitpt: prdy=%b after %0d cycles, want 1", pt_ready_b, n);
      end
      pt_valid_b = 1'b1;
      ready_b = 1'b0;
      tick();
      pt_valid_b = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cmd_b !== ID) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL st_hold: %0d non-ID cycles while ready low, want 0", bad);
      end
      ready_b = 1'b1;
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (cmd_b !== ST) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL st_after_ready: %0d non-ST cycles, want 0", bad);
      end
      tick();
      for (int k = 1; k < 16; k++) tick();
      ok_b = 1'b1;
      tick();
      ok_b = 1'b0;
      checks++;
      if (blk_b !== 16'd1 || tmo_b !== 1'b0 || pt_ready_b !== 1'b1) begin
         errors++;
         $display("FAIL ok_vs_tmo: blk=%0d tmo=%b prdy=%b, want 1 0 1", blk_b, tmo_b, pt_ready_b);
      end
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      checks++;
      if (blk_b !== 16'd0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL coinc_reset: blk=%0d busy=%b, want 0 0", blk_b, busy_b);
      end
   endtask

   // Full 20-block run with a cipher model answering 10 cycles after ST.
   task automatic test_full_run();
      int sk_runs, since, c;
      logic [1:0] prev;
      sk_runs = 0;
      since = -1;
      prev = ID;
      pt_b = 128'hdeadbeef0123456789abcdeffedcba98;
      pt_valid_b = 1'b1;
      ready_b = 1'b1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      c = 0;
      while (done_b !== 1'b1 && c < 2000) begin
         if (cmd_b == SK && prev != SK) sk_runs++;
         if (cmd_b == ST) since = 0;
         else if (since >= 0) since++;
         if (since == 10) begin
            ok_b = 1'b1;
            since = -1;
         end else begin
            ok_b = 1'b0;
         end
         prev = cmd_b;
         tick();
         c++;
      end
      ok_b = 1'b0;
      pt_valid_b = 1'b0;
      checks++;
      if (done_b !== 1'b1 || blk_b !== 16'd20 || busy_b !== 1'b0 || tmo_b !== 1'b0) begin
         errors++;
         $display("FAIL full_run: done=%b blk=%0d busy=%b tmo=%b after %0d cycles, want 1 20 0 0",
                  done_b, blk_b, busy_b, tmo_b, c);
      end
      checks++;
      if (sk_runs != 1) begin
         errors++;
         $display("FAIL key_once: SK phases=%0d, want 1", sk_runs);
      end
      tick(); tick(); tick();
      checks++;
      if (done_b !== 1'b1 || blk_b !== 16'd20) begin
         errors++;
         $display("FAIL done_hold: done=%b blk=%0d, want 1 20", done_b, blk_b);
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      checks++;
      if (done_b !== 1'b0 || blk_b !== 16'd0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL done_restart: done=%b blk=%0d busy=%b, want 0 0 0", done_b, blk_b, busy_b);
      end
   endtask

   initial begin
      test_reset();
      test_key_load();
      test_reset_mid_pt();
      test_pt_load();
      test_timeout();
      test_coincident_ok();
      test_full_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
